audio_song_arbiter: RTL and testbench
=====================================

// Module: audio_song_arbiter
// PURPOSE
//   Shares the single I2S tone path between two song players (song 1, song 2).
//   Grants one player at a time, whole-song hold, round-robin on release.
//   Times each note in I2S sample frames and drives tone/CS1/CS2/play into the I2S block.
//   Sits between the two song ROM sequencers and the audio output module.
// PARAMETERS
//   TONE_W      8      tone code width
//   NOTE_TICKS  12000  sample frames per note (>=1)
//   GAP_TICKS   480    silent sample frames between notes (0 = no gap)
//   CNT_W       16     frame counter width; must hold max(NOTE_TICKS, GAP_TICKS)
// PORTS
//   clk        in   1       system clock
//   reset      in   1       synchronous, active-low reset
//   lrck_tick  in   1       1-cycle pulse per I2S sample frame
//   stop       in   1       synchronous abort to IDLE
//   req1       in   1       song 1 wants the output; hold high for whole song
//   tone1      in   TONE_W  song 1 current tone code
//   req2       in   1       song 2 wants the output
//   tone2      in   TONE_W  song 2 current tone code
//   tone_out   out  TONE_W  tone to I2S block
//   cs1        out  1       song 1 selected
//   cs2        out  1       song 2 selected
//   play       out  1       I2S output enable
//   note_adv1  out  1       1-cycle pulse: song 1 advance to next tone
//   note_adv2  out  1       1-cycle pulse: song 2 advance to next tone
//   busy       out  1       state != IDLE
// BEHAVIOUR
//   - All outputs registered. While reset==0 at a clk edge:
//     - state=IDLE, all outputs 0, counter 0, last_grant=2 (song 1 wins first tie).
//   - States: IDLE, NOTE, GAP.
//   - IDLE: outputs 0. If req1|req2 at edge n:
//     - grant = sole requester; if both, the one != last_grant.
//     - Capture that tone; enter NOTE.
//     - cs/tone_out valid at n+1 (1-cycle latency).
//   - NOTE:
//     - cs of grant=1; tone_out holds captured tone.
//     - play=1 unless tone==0 (rest: play=0, still timed).
//     - Counter starts at 0 on entry; a lrck_tick in the entry cycle is not counted.
//     - On the NOTE_TICKS-th tick: pulse note_adv of grant for exactly 1 cycle, clear counter.
//       - GAP_TICKS>0 -> GAP.
//       - GAP_TICKS==0 -> re-evaluate as GAP exit.
//   - GAP:
//     - play=0; cs and tone_out held.
//     - After GAP_TICKS ticks: if granted req still 1, capture its tone, enter NOTE.
//     - Else release: last_grant=grant, cs=0, tone_out=0 -> IDLE.
//     - A waiting requester is granted on the next cycle from IDLE (no back-to-back grant in same cycle).
//   - Granted req drops during NOTE:
//     - Abort note, no note_adv pulse, play=0 next cycle; go GAP, then release.
//   - Non-granted req changes: ignored until release (no pre-emption).
//   - stop=1: next state IDLE from any state.
//     - Outputs 0 next cycle, no note_adv.
//     - last_grant=current grant if one was active.
//     - stop wins over simultaneous req or tick.
//   - note_adv1 and note_adv2 never both 1; cs1 and cs2 never both 1.
//   - Counter saturates, never wraps; ticks in IDLE ignored.
// STRUCTURE
//   - audio_defs.vh: state encodings, TONE_REST=0, GRANT_NONE/1/2 codes, default NOTE/GAP ticks.
//   - Sub-module frame_timer: CNT_W counter.
//     - Inputs: clear, tick, target.
//     - Output: done pulse on target-th tick.
//     - Reused for NOTE and GAP phases.
//   - Arbiter FSM and output registers live in this module.
// TESTING (NOTE_TICKS=4, GAP_TICKS=2, tick every 3 clks)
//   - Reset: reset=0 two cycles with req1=1 -> all outputs 0, busy=0; reset=1 -> cs1=1 next cycle.
//   - Single song: req1=1, tone1=8'h23 held -> tone_out=23, play=1 for 4 ticks;
//     note_adv1 one pulse; play=0 for 2 ticks; new tone captured.
//   - Tie/round-robin: req1=req2=1 from reset -> cs1 first.
//     Drop req1 -> after gap cs1=0, IDLE 1 cycle, then cs2=1.
//     Re-raise req1 while song 2 plays -> no pre-emption.
//   - Rest: tone1=0 -> play=0 but note_adv1 still pulses after 4 ticks.
//   - Abort: drop req2 at tick 2 of NOTE -> no note_adv2, play=0 next cycle, release after 2 ticks.
//   - Stop: stop=1 mid-NOTE with a simultaneous tick -> next cycle all outputs 0, busy=0, no adv pulse.

Source files
------------

// File: rtl/audio_song_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// audio_song_arbiter_pkg
// Shared definitions for the song arbiter: FSM state encodings, grant codes,
// the rest tone code, default timing values and the round-robin pick helper.
// No ports (package).
// -----------------------------------------------------------------------------
package audio_song_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NOTE = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_1    = 2'd1,
        GRANT_2    = 2'd2
    } grant_t;

    // Tone code that means "rest": timed like a note, but play stays low.
    localparam int TONE_REST = 0;

    localparam int DEF_TONE_W     = 8;
    localparam int DEF_NOTE_TICKS = 12000;
    localparam int DEF_GAP_TICKS  = 480;
    localparam int DEF_CNT_W      = 16;

    // Sole requester wins; on a tie the player that did not hold the output
    // last time wins.
    function automatic grant_t pick_grant(input logic r1, input logic r2,
                                          input grant_t last);
        if (r1 && r2)
            return (last == GRANT_1) ? GRANT_2 : GRANT_1;
        else if (r2)
            return GRANT_2;
        else if (r1)
            return GRANT_1;
        else
            return GRANT_NONE;
    endfunction

endpackage

// File: rtl/audio_song_arbiter_frame_timer.sv
// -----------------------------------------------------------------------------
// audio_song_arbiter_frame_timer
// Counts I2S sample-frame ticks and pulses done on the target-th tick, then
// restarts from zero. Shared by the NOTE and GAP phases of the arbiter.
//   clk      in   system clock
//   reset    in   synchronous active-low reset
//   i_clear  in   force the count to zero; a tick in the same cycle is dropped
//   i_tick   in   1-cycle frame tick
//   i_target in   number of ticks per phase (0 = never done)
//   o_done   out  combinational pulse on the cycle of the target-th tick
// -----------------------------------------------------------------------------
module audio_song_arbiter_frame_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clear,
    input  logic             i_tick,
    input  logic [CNT_W-1:0] i_target,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W:0]   w_next;

    // One bit wider so the compare cannot wrap when the count is at its max.
    assign w_next = {1'b0, r_count} + (CNT_W + 1)'(1);
    assign o_done = i_tick && !i_clear && (i_target != '0) &&
                    (w_next == {1'b0, i_target});

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_clear || o_done) begin
            r_count <= '0;
        end else if (i_tick && (r_count != '1)) begin
            // Saturates rather than wrapping.
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/audio_song_arbiter.sv
// -----------------------------------------------------------------------------
// audio_song_arbiter
// Shares one I2S tone path between two song players. One player holds the
// output for its whole song; on release the other player wins a tie. Each
// note lasts NOTE_TICKS sample frames followed by GAP_TICKS silent frames.
//   clk        in   system clock
//   reset      in   synchronous active-low reset
//   lrck_tick  in   1-cycle pulse per I2S sample frame
//   stop       in   synchronous abort to IDLE (beats req and tick)
//   req1/req2  in   player wants the output, held for the whole song
//   tone1/2    in   player's current tone code
//   tone_out   out  tone to the I2S block
//   cs1/cs2    out  player selected
//   play       out  I2S output enable (low for rests and gaps)
//   note_adv1/2 out 1-cycle pulse: player moves on to its next tone
//   busy       out  arbiter not IDLE
//   dbg_state  out  current FSM state (state_t encoding)
// Handshake: a player raises req and keeps it high for the whole song; each
// note_adv pulse tells it to present its next tone, which is sampled at the
// end of the following gap. Dropping req ends the song (aborting any note in
// progress without a note_adv pulse).
// -----------------------------------------------------------------------------
module audio_song_arbiter
    import audio_song_arbiter_pkg::*;
#(
    parameter int TONE_W     = DEF_TONE_W,
    parameter int NOTE_TICKS = DEF_NOTE_TICKS,
    parameter int GAP_TICKS  = DEF_GAP_TICKS,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              lrck_tick,
    input  logic              stop,
    input  logic              req1,
    input  logic [TONE_W-1:0] tone1,
    input  logic              req2,
    input  logic [TONE_W-1:0] tone2,
    output logic [TONE_W-1:0] tone_out,
    output logic              cs1,
    output logic              cs2,
    output logic              play,
    output logic              note_adv1,
    output logic              note_adv2,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    state_t            r_state;
    grant_t            r_grant;
    grant_t            r_last_grant;
    logic [TONE_W-1:0] r_tone_out;
    logic              r_cs1;
    logic              r_cs2;
    logic              r_play;
    logic              r_adv1;
    logic              r_adv2;
    logic              r_busy;

    grant_t            w_pick;
    logic [TONE_W-1:0] w_pick_tone;
    logic              w_grant_req;
    logic [TONE_W-1:0] w_grant_tone;
    logic [CNT_W-1:0]  w_target;
    logic              w_clear;
    logic              w_done;

    assign w_pick      = pick_grant(req1, req2, r_last_grant);
    assign w_pick_tone = (w_pick == GRANT_2) ? tone2 : tone1;

    assign w_grant_req  = (r_grant == GRANT_1) ? req1 :
                          (r_grant == GRANT_2) ? req2 : 1'b0;
    assign w_grant_tone = (r_grant == GRANT_2) ? tone2 : tone1;

    assign w_target = (r_state == ST_GAP) ? CNT_W'(GAP_TICKS) : CNT_W'(NOTE_TICKS);

    // The timer is held at zero while idle and restarted on every abort, so
    // the tick in the cycle that enters a phase never counts toward it.
    assign w_clear = stop || (r_state == ST_IDLE) ||
                     ((r_state == ST_NOTE) && !w_grant_req);

    audio_song_arbiter_frame_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_tick   (lrck_tick),
        .i_target (w_target),
        .o_done   (w_done)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= GRANT_NONE;
            r_last_grant <= GRANT_2;   // song 1 wins the first tie
            r_tone_out   <= '0;
            r_cs1        <= 1'b0;
            r_cs2        <= 1'b0;
            r_play       <= 1'b0;
            r_adv1       <= 1'b0;
            r_adv2       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_adv1 <= 1'b0;
            r_adv2 <= 1'b0;
            if (stop) begin
                if (r_state != ST_IDLE)
                    r_last_grant <= r_grant;
                r_state    <= ST_IDLE;
                r_grant    <= GRANT_NONE;
                r_tone_out <= '0;
                r_cs1      <= 1'b0;
                r_cs2      <= 1'b0;
                r_play     <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (req1 || req2) begin
                            r_state    <= ST_NOTE;
                            r_grant    <= w_pick;
                            r_cs1      <= (w_pick == GRANT_1);
                            r_cs2      <= (w_pick == GRANT_2);
                            r_tone_out <= w_pick_tone;
                            r_play     <= (w_pick_tone != TONE_W'(TONE_REST));
                            r_busy     <= 1'b1;
                        end
                    end
                    ST_NOTE: begin
                        if (!w_grant_req) begin
                            // Song ended mid-note: silence now, no advance.
                            r_play <= 1'b0;
                            if (GAP_TICKS == 0) begin
                                r_state      <= ST_IDLE;
                                r_last_grant <= r_grant;
                                r_grant      <= GRANT_NONE;
                                r_tone_out   <= '0;
                                r_cs1        <= 1'b0;
                                r_cs2        <= 1'b0;
                                r_busy       <= 1'b0;
                            end else begin
                                r_state <= ST_GAP;
                            end
                        end else if (w_done) begin
                            r_adv1 <= (r_grant == GRANT_1);
                            r_adv2 <= (r_grant == GRANT_2);
                            if (GAP_TICKS == 0) begin
                                // No gap: the note boundary doubles as gap exit.
                                r_tone_out <= w_grant_tone;
                                r_play     <= (w_grant_tone != TONE_W'(TONE_REST));
                            end else begin
                                r_state <= ST_GAP;
                                r_play  <= 1'b0;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (w_done) begin
                            if (w_grant_req) begin
                                r_state    <= ST_NOTE;
                                r_tone_out <= w_grant_tone;
                                r_play     <= (w_grant_tone != TONE_W'(TONE_REST));
                            end else begin
                                // Release; a waiting player is granted from IDLE
                                // on the following cycle.
                                r_state      <= ST_IDLE;
                                r_last_grant <= r_grant;
                                r_grant      <= GRANT_NONE;
                                r_tone_out   <= '0;
                                r_cs1        <= 1'b0;
                                r_cs2        <= 1'b0;
                                r_play       <= 1'b0;
                                r_busy       <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tone_out  = r_tone_out;
    assign cs1       = r_cs1;
    assign cs2       = r_cs2;
    assign play      = r_play;
    assign note_adv1 = r_adv1;
    assign note_adv2 = r_adv2;
    assign busy      = r_busy;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_audio_song_arbiter.sv
// -----------------------------------------------------------------------------
// tb_audio_song_arbiter
// Directed bench for audio_song_arbiter with NOTE_TICKS=4, GAP_TICKS=2 and a
// frame tick on every third clock (global cycles 0, 3, 6, ...). Each table row
// holds the inputs for n cycles and the output bundle expected after every
// one of those cycles:
//   {tone_out, cs1, cs2, play, note_adv1, note_adv2, busy}
// -----------------------------------------------------------------------------
module tb_audio_song_arbiter;

    localparam int TONE_W     = 8;
    localparam int NOTE_TICKS = 4;
    localparam int GAP_TICKS  = 2;
    localparam int CNT_W      = 16;
    localparam int OUT_W      = TONE_W + 6;

    typedef struct {
        int                n;
        logic              rst_n;
        logic              stp;
        logic              r1;
        logic [TONE_W-1:0] t1;
        logic              r2;
        logic [TONE_W-1:0] t2;
        logic [OUT_W-1:0]  exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset     = 1'b0;
    logic              lrck_tick = 1'b0;
    logic              stop      = 1'b0;
    logic              req1      = 1'b0;
    logic              req2      = 1'b0;
    logic [TONE_W-1:0] tone1     = '0;
    logic [TONE_W-1:0] tone2     = '0;
    logic [TONE_W-1:0] tone_out;
    logic              cs1;
    logic              cs2;
    logic              play;
    logic              note_adv1;
    logic              note_adv2;
    logic              busy;
    logic [1:0]        dbg_state;

    audio_song_arbiter #(
        .TONE_W     (TONE_W),
        .NOTE_TICKS (NOTE_TICKS),
        .GAP_TICKS  (GAP_TICKS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .lrck_tick (lrck_tick),
        .stop      (stop),
        .req1      (req1),
        .tone1     (tone1),
        .req2      (req2),
        .tone2     (tone2),
        .tone_out  (tone_out),
        .cs1       (cs1),
        .cs2       (cs2),
        .play      (play),
        .note_adv1 (note_adv1),
        .note_adv2 (note_adv2),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int               n_checks = 0;
    int               n_pass   = 0;
    int               cyc      = 0;
    logic [OUT_W-1:0] exp_q[$];
    vec_t             tbl[$];
    logic [OUT_W-1:0] w_act;

    assign w_act = {tone_out, cs1, cs2, play, note_adv1, note_adv2, busy};

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    function automatic logic [OUT_W-1:0] o(input logic [TONE_W-1:0] t,
        input logic c1, input logic c2, input logic p, input logic a1,
        input logic a2, input logic b);
        return {t, c1, c2, p, a1, a2, b};
    endfunction

    function automatic vec_t mk(input int n, input logic rn, input logic st,
        input logic r1, input logic [TONE_W-1:0] t1, input logic r2,
        input logic [TONE_W-1:0] t2, input logic [OUT_W-1:0] e);
        vec_t v;
        v.n = n; v.rst_n = rn; v.stp = st; v.r1 = r1; v.t1 = t1;
        v.r2 = r2; v.t2 = t2; v.exp = e;
        return v;
    endfunction

    // Mutual-exclusion properties hold on every cycle.
    always @(negedge clk) begin
        check("cs_exclusive", {31'b0, cs1 & cs2}, 32'd0);
        check("adv_exclusive", {31'b0, note_adv1 & note_adv2}, 32'd0);
    end

    // ---------------- driver ----------------
    task automatic step();
        lrck_tick = (cyc % 3 == 0);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TONE_W-1:0] t_rand;
        int                ticks;
        bit                got;

        // --- Reset, single song, new tone, rest note, release (cycles 0..57)
        tbl.push_back(mk( 2, 0, 0, 1, 8'h23, 0, 8'h00, o(8'h00, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h23, 0, 8'h00, o(8'h23, 1, 0, 1, 0, 0, 1)));
        tbl.push_back(mk( 9, 1, 0, 1, 8'h23, 0, 8'h00, o(8'h23, 1, 0, 1, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h23, 0, 8'h00, o(8'h23, 1, 0, 0, 1, 0, 1)));
        tbl.push_back(mk( 5, 1, 0, 1, 8'h45, 0, 8'h00, o(8'h23, 1, 0, 0, 0, 0, 1)));
        tbl.push_back(mk(12, 1, 0, 1, 8'h45, 0, 8'h00, o(8'h45, 1, 0, 1, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h45, 0, 8'h00, o(8'h45, 1, 0, 0, 1, 0, 1)));
        tbl.push_back(mk( 5, 1, 0, 1, 8'h00, 0, 8'h00, o(8'h45, 1, 0, 0, 0, 0, 1)));
        tbl.push_back(mk(12, 1, 0, 1, 8'h00, 0, 8'h00, o(8'h00, 1, 0, 0, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h00, 0, 8'h00, o(8'h00, 1, 0, 0, 1, 0, 1)));
        tbl.push_back(mk( 5, 1, 0, 0, 8'h00, 0, 8'h00, o(8'h00, 1, 0, 0, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 0, 8'h00, 0, 8'h00, o(8'h00, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk( 3, 1, 0, 0, 8'h00, 0, 8'h00, o(8'h00, 0, 0, 0, 0, 0, 0)));
        // --- Tie from reset, release to song 2, no pre-emption (58..92)
        tbl.push_back(mk( 1, 0, 0, 1, 8'h11, 1, 8'h22, o(8'h00, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h11, 1, 8'h22, o(8'h11, 1, 0, 1, 0, 0, 1)));
        tbl.push_back(mk( 9, 1, 0, 1, 8'h11, 1, 8'h22, o(8'h11, 1, 0, 1, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h11, 1, 8'h22, o(8'h11, 1, 0, 0, 1, 0, 1)));
        tbl.push_back(mk( 5, 1, 0, 0, 8'h11, 1, 8'h22, o(8'h11, 1, 0, 0, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 0, 8'h11, 1, 8'h22, o(8'h00, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk( 1, 1, 0, 0, 8'h11, 1, 8'h22, o(8'h22, 0, 1, 1, 0, 0, 1)));
        tbl.push_back(mk(10, 1, 0, 1, 8'h11, 1, 8'h22, o(8'h22, 0, 1, 1, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h11, 1, 8'h22, o(8'h22, 0, 1, 0, 0, 1, 1)));
        tbl.push_back(mk( 5, 1, 0, 1, 8'h11, 1, 8'h33, o(8'h22, 0, 1, 0, 0, 0, 1)));
        // --- Song 2 aborted at tick 2 of its note, then song 1 waits in (93..116)
        tbl.push_back(mk( 1, 1, 0, 1, 8'h11, 1, 8'h33, o(8'h33, 0, 1, 1, 0, 0, 1)));
        tbl.push_back(mk( 5, 1, 0, 1, 8'h11, 1, 8'h33, o(8'h33, 0, 1, 1, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h11, 0, 8'h33, o(8'h33, 0, 1, 0, 0, 0, 1)));
        tbl.push_back(mk( 5, 1, 0, 1, 8'h11, 0, 8'h33, o(8'h33, 0, 1, 0, 0, 0, 1)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h11, 0, 8'h33, o(8'h00, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h11, 0, 8'h33, o(8'h11, 1, 0, 1, 0, 0, 1)));
        tbl.push_back(mk(10, 1, 0, 1, 8'h11, 0, 8'h33, o(8'h11, 1, 0, 1, 0, 0, 1)));
        // --- Stop on the tick that would end the note; stop records song 1 (117..120)
        tbl.push_back(mk( 1, 1, 1, 1, 8'h11, 0, 8'h33, o(8'h00, 0, 0, 0, 0, 0, 0)));
        tbl.push_back(mk( 1, 1, 0, 1, 8'h11, 1, 8'h44, o(8'h44, 0, 1, 1, 0, 0, 1)));
        tbl.push_back(mk( 2, 1, 1, 1, 8'h11, 1, 8'h44, o(8'h00, 0, 0, 0, 0, 0, 0)));

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                reset = tbl[i].rst_n;
                stop  = tbl[i].stp;
                req1  = tbl[i].r1;
                tone1 = tbl[i].t1;
                req2  = tbl[i].r2;
                tone2 = tbl[i].t2;
                exp_q.push_back(tbl[i].exp);
                step();
                check($sformatf("row%0d_cycle%0d", i, cyc - 1), {18'b0, w_act},
                      {18'b0, exp_q.pop_front()});
            end
        end

        // --- Hand sequence: lone song 2, count frames from grant to advance
        t_rand = TONE_W'($urandom_range(1, 255));
        stop  = 1'b0;
        req1  = 1'b0;
        req2  = 1'b1;
        tone2 = t_rand;
        step();
        check("solo_grant", {18'b0, w_act}, {18'b0, o(t_rand, 0, 1, 1, 0, 0, 1)});

        ticks = 0;
        got   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (lrck_tick)
                ticks++;
            if (note_adv2) begin
                got = 1'b1;
                break;
            end
        end
        check("solo_adv_seen", {31'b0, got}, 32'd1);
        check("solo_ticks_per_note", ticks, NOTE_TICKS);
        check("solo_no_adv1", {31'b0, note_adv1}, 32'd0);

        req2 = 1'b0;
        step();
        check("solo_adv_one_cycle", {18'b0, w_act}, {18'b0, o(t_rand, 0, 1, 0, 0, 0, 1)});

        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (!busy) begin
                got = 1'b1;
                break;
            end
        end
        check("solo_released", {31'b0, got}, 32'd1);
        check("solo_idle_outputs", {18'b0, w_act}, {18'b0, o(8'h00, 0, 0, 0, 0, 0, 0)});
        check("solo_idle_state", {30'b0, dbg_state}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
